// File: rtl/qam_symbol_mapper_pkg.sv
// ofdm_tx_pkg: shared constants and types for the OFDM transmit slice.
// Covers rate codes, phase encodings, field lengths, the modulation and level-mode enums,
// and a rate-code decoder.
package ofdm_tx_pkg;

    // Rate codes seen on the rate port. Any other code means BPSK.
    localparam logic [3:0] RATE_QPSK  = 4'b0101;
    localparam logic [3:0] RATE_QAM16 = 4'b1001;

    // FSM states double as the phase output encoding.
    localparam logic [1:0] PH_PRE  = 2'b00;
    localparam logic [1:0] PH_SIG  = 2'b01;
    localparam logic [1:0] PH_DATA = 2'b11;

    // Field lengths in bit pairs and subcarriers.
    localparam int unsigned PRE_PAIRS = 18;
    localparam int unsigned SIG_PAIRS = 24;
    localparam int unsigned N_SC_PRE  = 2 * PRE_PAIRS;
    localparam int unsigned N_SC_DATA = 48;

    // Modulation applied to the DATA field.
    typedef enum logic [1:0] {
        MOD_BPSK  = 2'b00,
        MOD_QPSK  = 2'b01,
        MOD_QAM16 = 2'b10
    } mod_e;

    // Level selection for one output axis.
    typedef enum logic [1:0] {
        LVL_ZERO = 2'b00,
        LVL_BPSK = 2'b01,
        LVL_QPSK = 2'b10,
        LVL_QAM  = 2'b11
    } lvl_mode_e;

    // Decode a 4-bit rate code into the DATA modulation.
    function automatic mod_e rate_to_mod(input logic [3:0] rate_code);
        mod_e m;
        case (rate_code)
            RATE_QPSK:  m = MOD_QPSK;
            RATE_QAM16: m = MOD_QAM16;
            default:    m = MOD_BPSK;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/qam_symbol_mapper_if.sv
// Bit-pair stream from the data interleaver into the symbol mapper.
// There is no backpressure, so the sink must take every valid pair.
interface qam_symbol_mapper_if;
    logic A_in;
    logic B_in;
    logic AB_in_valid;

    modport master (output A_in, output B_in, output AB_in_valid);
    modport slave  (input  A_in, input  B_in, input  AB_in_valid);
endinterface

// File: rtl/qam_symbol_mapper_level_lut.sv
// qam_level_lut: combinational mapping from 2 bits to a signed level on one axis.
// BPSK and QPSK look only at bits[0] (0 -> negative, 1 -> positive).
// 16-QAM reads bits as a Gray pair: 00 -> -L3, 01 -> -L1, 11 -> +L1, 10 -> +L3.
module qam_level_lut
    import ofdm_tx_pkg::*;
#(
    parameter int IQ_W   = 8,
    parameter int L_BPSK = 64,
    parameter int L_QPSK = 45,
    parameter int L_QAM1 = 20,
    parameter int L_QAM3 = 61
) (
    input  lvl_mode_e              mode,
    input  logic [1:0]             bits,
    output logic signed [IQ_W-1:0] level
);

    localparam logic signed [IQ_W-1:0] P_BPSK = IQ_W'(L_BPSK);
    localparam logic signed [IQ_W-1:0] N_BPSK = IQ_W'(-L_BPSK);
    localparam logic signed [IQ_W-1:0] P_QPSK = IQ_W'(L_QPSK);
    localparam logic signed [IQ_W-1:0] N_QPSK = IQ_W'(-L_QPSK);
    localparam logic signed [IQ_W-1:0] P_QAM1 = IQ_W'(L_QAM1);
    localparam logic signed [IQ_W-1:0] N_QAM1 = IQ_W'(-L_QAM1);
    localparam logic signed [IQ_W-1:0] P_QAM3 = IQ_W'(L_QAM3);
    localparam logic signed [IQ_W-1:0] N_QAM3 = IQ_W'(-L_QAM3);

    // Select the amplitude for the requested mode and bit pattern.
    always_comb begin
        level = '0;
        case (mode)
            LVL_BPSK: level = bits[0] ? P_BPSK : N_BPSK;
            LVL_QPSK: level = bits[0] ? P_QPSK : N_QPSK;
            LVL_QAM: begin
                case (bits)
                    2'b00:   level = N_QAM3;
                    2'b01:   level = N_QAM1;
                    2'b11:   level = P_QAM1;
                    2'b10:   level = P_QAM3;
                    default: level = '0;
                endcase
            end
            default:  level = '0;
        endcase
    end

endmodule

// File: rtl/qam_symbol_mapper.sv
// qam_symbol_mapper: maps interleaved bit pairs to signed I/Q constellation points.
// PRE (18 pairs) and SIG (24 pairs) always use BPSK. DATA uses the rate latched on the last
// SIG pair and stays in DATA until reset.
// Optional feature: define QAM_MAPPER_SYMCOUNT_EN to add the sym_count output. This is a
// saturating count of completed DATA symbols.
module qam_symbol_mapper
    import ofdm_tx_pkg::*;
#(
    parameter int IQ_W   = 8,
    parameter int L_BPSK = 64,
    parameter int L_QPSK = 45,
    parameter int L_QAM1 = 20,
    parameter int L_QAM3 = 61
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic [3:0]             rate,
    qam_symbol_mapper_if.slave     ab_if,
    output logic signed [IQ_W-1:0] I0_out,
    output logic signed [IQ_W-1:0] Q0_out,
    output logic signed [IQ_W-1:0] I1_out,
    output logic signed [IQ_W-1:0] Q1_out,
    output logic [1:0]             IQ_valid,
    output logic [5:0]             sc_index,
    output logic                   sym_end,
    output logic [1:0]             phase
`ifdef QAM_MAPPER_SYMCOUNT_EN
    ,
    output logic [15:0]            sym_count
`endif
);

    localparam logic [5:0] END_PRE  = 6'(N_SC_PRE);
    localparam logic [5:0] END_SIG  = 6'(2 * SIG_PAIRS);
    localparam logic [5:0] END_DATA = 6'(N_SC_DATA);

    // Sequencing state
    logic [1:0] phase_q, phase_d;
    logic [5:0] sc_q, sc_d;
    mod_e       mod_q, mod_d;
    logic       pend_q, pend_d;
    logic [1:0] pend_bits_q, pend_bits_d;

    // Output registers
    logic signed [IQ_W-1:0] i0_q, i0_d;
    logic signed [IQ_W-1:0] q0_q, q0_d;
    logic signed [IQ_W-1:0] i1_q, i1_d;
    logic [1:0]             iq_valid_q, iq_valid_d;
    logic [5:0]             sc_out_q, sc_out_d;
    logic                   sym_end_q, sym_end_d;
    logic [1:0]             phase_out_q, phase_out_d;

    // Per-pair decode
    mod_e                   mod_s;
    lvl_mode_e              i0_mode_s, q0_mode_s, i1_mode_s;
    logic [1:0]             i0_bits_s, q0_bits_s, i1_bits_s;
    logic signed [IQ_W-1:0] i0_lvl_s, q0_lvl_s, i1_lvl_s;
    logic [5:0]             step_s, sc_next_s, field_end_s;
    logic                   hold_half_s, last_s;

    // Choose the modulation for the incoming pair and steer the bits to each axis LUT.
    always_comb begin
        mod_s = (phase_q == PH_DATA) ? mod_q : MOD_BPSK;
        case (mod_s)
            MOD_QPSK: begin
                i0_mode_s = LVL_QPSK;  i0_bits_s = {1'b0, ab_if.A_in};
                q0_mode_s = LVL_QPSK;  q0_bits_s = {1'b0, ab_if.B_in};
                i1_mode_s = LVL_ZERO;  i1_bits_s = 2'b00;
                step_s    = 6'd1;
            end
            MOD_QAM16: begin
                i0_mode_s = LVL_QAM;   i0_bits_s = pend_bits_q;
                q0_mode_s = LVL_QAM;   q0_bits_s = {ab_if.A_in, ab_if.B_in};
                i1_mode_s = LVL_ZERO;  i1_bits_s = 2'b00;
                step_s    = 6'd1;
            end
            default: begin
                i0_mode_s = LVL_BPSK;  i0_bits_s = {1'b0, ab_if.A_in};
                q0_mode_s = LVL_ZERO;  q0_bits_s = 2'b00;
                i1_mode_s = LVL_BPSK;  i1_bits_s = {1'b0, ab_if.B_in};
                step_s    = 6'd2;
            end
        endcase
        case (phase_q)
            PH_PRE:  field_end_s = END_PRE;
            PH_SIG:  field_end_s = END_SIG;
            default: field_end_s = END_DATA;
        endcase
        // In 16-QAM, a pair with nothing pending is only the first half of a point.
        hold_half_s = (mod_s == MOD_QAM16) && !pend_q;
        sc_next_s   = sc_q + step_s;
        last_s      = (sc_next_s == field_end_s);
    end

    qam_level_lut #(
        .IQ_W(IQ_W), .L_BPSK(L_BPSK), .L_QPSK(L_QPSK), .L_QAM1(L_QAM1), .L_QAM3(L_QAM3)
    ) u_lut_i0 (
        .mode(i0_mode_s), .bits(i0_bits_s), .level(i0_lvl_s)
    );

    qam_level_lut #(
        .IQ_W(IQ_W), .L_BPSK(L_BPSK), .L_QPSK(L_QPSK), .L_QAM1(L_QAM1), .L_QAM3(L_QAM3)
    ) u_lut_q0 (
        .mode(q0_mode_s), .bits(q0_bits_s), .level(q0_lvl_s)
    );

    qam_level_lut #(
        .IQ_W(IQ_W), .L_BPSK(L_BPSK), .L_QPSK(L_QPSK), .L_QAM1(L_QAM1), .L_QAM3(L_QAM3)
    ) u_lut_i1 (
        .mode(i1_mode_s), .bits(i1_bits_s), .level(i1_lvl_s)
    );

    // Next-state logic: field FSM, subcarrier counter, pending half-point and output capture.
    always_comb begin
        phase_d     = phase_q;
        sc_d        = sc_q;
        mod_d       = mod_q;
        pend_d      = pend_q;
        pend_bits_d = pend_bits_q;
        // On idle cycles lane0 data, index and phase hold, while flags and lane1 drop.
        i0_d        = i0_q;
        q0_d        = q0_q;
        i1_d        = '0;
        iq_valid_d  = 2'b00;
        sc_out_d    = sc_out_q;
        sym_end_d   = 1'b0;
        phase_out_d = phase_out_q;
        if (ab_if.AB_in_valid) begin
            if (hold_half_s) begin
                pend_d      = 1'b1;
                pend_bits_d = {ab_if.A_in, ab_if.B_in};
            end else begin
                pend_d      = 1'b0;
                i0_d        = i0_lvl_s;
                q0_d        = q0_lvl_s;
                i1_d        = i1_lvl_s;
                iq_valid_d  = (mod_s == MOD_BPSK) ? 2'b11 : 2'b01;
                sc_out_d    = sc_q;
                sym_end_d   = last_s;
                phase_out_d = phase_q;
                if (last_s) begin
                    sc_d = 6'd0;
                    case (phase_q)
                        PH_PRE:  phase_d = PH_SIG;
                        PH_SIG: begin
                            phase_d = PH_DATA;
                            mod_d   = rate_to_mod(rate);
                        end
                        default: phase_d = phase_q;
                    endcase
                end else begin
                    sc_d = sc_next_s;
                end
            end
        end else begin
            pend_d = pend_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            phase_q     <= PH_PRE;
            sc_q        <= 6'd0;
            mod_q       <= MOD_BPSK;
            pend_q      <= 1'b0;
            pend_bits_q <= 2'b00;
            i0_q        <= '0;
            q0_q        <= '0;
            i1_q        <= '0;
            iq_valid_q  <= 2'b00;
            sc_out_q    <= 6'd0;
            sym_end_q   <= 1'b0;
            phase_out_q <= PH_PRE;
        end else begin
            phase_q     <= phase_d;
            sc_q        <= sc_d;
            mod_q       <= mod_d;
            pend_q      <= pend_d;
            pend_bits_q <= pend_bits_d;
            i0_q        <= i0_d;
            q0_q        <= q0_d;
            i1_q        <= i1_d;
            iq_valid_q  <= iq_valid_d;
            sc_out_q    <= sc_out_d;
            sym_end_q   <= sym_end_d;
            phase_out_q <= phase_out_d;
        end
    end

    assign I0_out   = i0_q;
    assign Q0_out   = q0_q;
    assign I1_out   = i1_q;
    // Lane1 only carries BPSK points, so its quadrature is always zero.
    assign Q1_out   = '0;
    assign IQ_valid = iq_valid_q;
    assign sc_index = sc_out_q;
    assign sym_end  = sym_end_q;
    assign phase    = phase_out_q;

`ifdef QAM_MAPPER_SYMCOUNT_EN
    logic [15:0] sym_count_q, sym_count_d;

    // Count completed DATA symbols, saturating at all-ones.
    always_comb begin
        sym_count_d = sym_count_q;
        if (ab_if.AB_in_valid && !hold_half_s && last_s && (phase_q == PH_DATA)
            && (sym_count_q != 16'hFFFF)) begin
            sym_count_d = sym_count_q + 16'd1;
        end else begin
            sym_count_d = sym_count_q;
        end
    end

    // Symbol counter register.
    always_ff @(posedge Clk) begin
        if (!reset) begin
            sym_count_q <= 16'd0;
        end else begin
            sym_count_q <= sym_count_d;
        end
    end

    assign sym_count = sym_count_q;
`endif

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Bench for qam_symbol_mapper. A behavioural model pushes the expected point when a pair is
// driven, and the entry is popped and compared one clock later.
module tb_qam_symbol_mapper;

    logic        Clk = 1'b0;
    logic        reset;
    logic [3:0]  rate;
    logic signed [7:0] I0_out, Q0_out, I1_out, Q1_out;
    logic [1:0]  IQ_valid;
    logic [5:0]  sc_index;
    logic        sym_end;
    logic [1:0]  phase;
`ifdef QAM_MAPPER_SYMCOUNT_EN
    logic [15:0] sym_count;
`endif

    qam_symbol_mapper_if ab ();

    qam_symbol_mapper dut (
        .Clk(Clk), .reset(reset), .rate(rate), .ab_if(ab.slave),
        .I0_out(I0_out), .Q0_out(Q0_out), .I1_out(I1_out), .Q1_out(Q1_out),
        .IQ_valid(IQ_valid), .sc_index(sc_index), .sym_end(sym_end), .phase(phase)
`ifdef QAM_MAPPER_SYMCOUNT_EN
        , .sym_count(sym_count)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int i0; int q0; int i1; int q1; int vld; int sc; int se; int ph;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_last;
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;

    // Reference model state
    int       m_field;   // 0 PRE, 1 SIG, 2 DATA
    int       m_sc;
    int       m_mode;    // 0 BPSK, 1 QPSK, 2 QAM16
    bit       m_pend;
    bit [1:0] m_pb;
    int       m_syms;

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int gray_lvl(input bit [1:0] g);
        case (g)
            2'b00:   return -61;
            2'b01:   return -20;
            2'b11:   return 20;
            default: return 61;
        endcase
    endfunction

    task automatic model_reset();
        m_field = 0; m_sc = 0; m_mode = 0; m_pend = 1'b0; m_pb = 2'b00; m_syms = 0;
        m_last = '{default: 0};
        exp_q.delete();
    endtask

    task automatic model_pair(input bit a, input bit b);
        exp_t e;
        int   len;
        int   stp;
        bit   emit;
        e = '{default: 0};
        emit = 1'b1;
        stp = 0;
        if (m_field != 2 || m_mode == 0) begin
            e.i0 = a ? 64 : -64; e.i1 = b ? 64 : -64; e.vld = 3; stp = 2;
        end else if (m_mode == 1) begin
            e.i0 = a ? 45 : -45; e.q0 = b ? 45 : -45; e.vld = 1; stp = 1;
        end else if (!m_pend) begin
            m_pend = 1'b1; m_pb = {a, b}; emit = 1'b0;
        end else begin
            e.i0 = gray_lvl(m_pb); e.q0 = gray_lvl({a, b}); e.vld = 1; stp = 1;
            m_pend = 1'b0;
        end
        if (emit) begin
            len  = (m_field == 0) ? 36 : 48;
            e.sc = m_sc;
            e.ph = (m_field == 0) ? 0 : ((m_field == 1) ? 1 : 3);
            m_sc = m_sc + stp;
            e.se = (m_sc >= len) ? 1 : 0;
            if (e.se == 1) begin
                m_sc = 0;
                if (m_field == 2) begin
                    if (m_syms < 65535) m_syms++;
                end else begin
                    if (m_field == 1)
                        m_mode = (rate == 4'b0101) ? 1 : ((rate == 4'b1001) ? 2 : 0);
                    m_field++;
                end
            end
            exp_q.push_back(e);
            m_last = e;
        end
    endtask

    // One clock: drive a pair (or idle), then compare the registered result.
    task automatic step(input bit v, input bit a, input bit b);
        exp_t e;
        ab.AB_in_valid = v; ab.A_in = a; ab.B_in = b;
        if (v) model_pair(a, b);
        @(posedge Clk); #1;
        ab.AB_in_valid = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("I0", int'(I0_out), e.i0);
            check("Q0", int'(Q0_out), e.q0);
            check("I1", int'(I1_out), e.i1);
            check("Q1", int'(Q1_out), e.q1);
            check("IQ_valid", int'(IQ_valid), e.vld);
            check("sc_index", int'(sc_index), e.sc);
            check("sym_end", int'(sym_end), e.se);
            check("phase", int'(phase), e.ph);
        end else begin
            check("idle_IQ_valid", int'(IQ_valid), 0);
            check("idle_I1", int'(I1_out), 0);
            check("idle_Q1", int'(Q1_out), 0);
            check("idle_sym_end", int'(sym_end), 0);
            check("hold_I0", int'(I0_out), m_last.i0);
            check("hold_Q0", int'(Q0_out), m_last.q0);
            check("hold_sc", int'(sc_index), m_last.sc);
            check("hold_phase", int'(phase), m_last.ph);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ab.AB_in_valid = 1'b0; ab.A_in = 1'b0; ab.B_in = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("rst_I0", int'(I0_out), 0);
        check("rst_Q0", int'(Q0_out), 0);
        check("rst_I1", int'(I1_out), 0);
        check("rst_IQ_valid", int'(IQ_valid), 0);
        check("rst_sc", int'(sc_index), 0);
        check("rst_sym_end", int'(sym_end), 0);
        check("rst_phase", int'(phase), 0);
`ifdef QAM_MAPPER_SYMCOUNT_EN
        check("rst_sym_count", int'(sym_count), 0);
`endif
        reset = 1'b1;
    endtask

    initial begin
        rate = 4'b0000;
        ab.A_in = 1'b0; ab.B_in = 1'b0; ab.AB_in_valid = 1'b0;
        reset = 1'b0;

        // Run 1: PRE (0,1), SIG (1,1), then QPSK DATA
        do_reset();
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        rate = 4'b0101;
        for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 47; i++) step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);

        // Run 2: 16-QAM DATA, gaps inside a point, rate change ignored, reset mid-point
        do_reset();
        rate = 4'b1001;
        for (int i = 0; i < 18; i++) step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
        for (int i = 0; i < 24; i++) step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        rate = 4'b0101;
        for (int k = 0; k < 400 && m_syms < 3; k++)
            step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
        check("data_symbols", m_syms, 3);
`ifdef QAM_MAPPER_SYMCOUNT_EN
        check("sym_count", int'(sym_count), 3);
`endif
        step(1'b1, 1'b1, 1'b1);
        do_reset();
        step(1'b1, 1'b0, 1'b1);

        // Run 3: unrecognised rate code gives BPSK DATA with index wrap
        rate = 4'b0011;
        for (int i = 0; i < 17; i++) step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
        for (int i = 0; i < 24; i++) step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
        for (int i = 0; i < 26; i++) step(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
        step(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
